// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the core's execute stage to a word-addressed data memory. Byte, halfword and word
//   loads/stores become 32-bit memory reads and writes. Sub-word stores use read-modify-write,
//   sub-word loads are sign- or zero-extended, and misaligned requests are caught before any
//   memory access is issued.
//
// Parameters
//   MISALIGN_TRAP : 1 = misaligned request answers with o_resp_error and no memory access,
//                   0 = low address bits are cleared and the access proceeds aligned.
//
// Ports
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_req_* / o_req_ready : core request (write, size, unsigned, byte address, right-aligned data)
//   o_resp_*              : one-cycle completion pulse, extended load data, misalignment flag
//   o_mem_in_* / i_mem_in_ready   : memory write request and write-done pulse
//   o_mem_out_* / i_mem_out_*     : memory read request, read word and read-data-valid pulse

module load_store_unit #(
    parameter int unsigned MISALIGN_TRAP = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic [31:0] o_mem_in_addr,
    output logic [31:0] o_mem_in_data,
    output logic        o_mem_in_valid,
    input  logic        i_mem_in_ready,
    output logic [31:0] o_mem_out_addr,
    output logic        o_mem_out_valid,
    input  logic [31:0] i_mem_out_data,
    input  logic        i_mem_out_ready
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic        r_write;
    logic        r_is_word;
    logic        r_is_half;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;

    logic        w_accept;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_trap;
    logic [31:0] w_eff_addr;
    logic [31:0] w_merged;
    logic [31:0] w_load_data;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Size 3 decodes as word because only bit 1 is looked at.
    assign w_is_word    = i_req_size[1];
    assign w_is_half    = (i_req_size == 2'd1);
    assign w_misaligned = (w_is_half && i_req_addr[0]) || (w_is_word && (i_req_addr[1:0] != 2'b00));
    assign w_trap       = w_misaligned && (MISALIGN_TRAP != 0);
    assign w_accept     = i_req_valid && (r_state == StIdle);

    // Clearing the sub-size bits is a no-op for aligned requests, so it is applied always.
    always_comb begin
        w_eff_addr = i_req_addr;
        if (w_is_word) begin
            w_eff_addr[1:0] = 2'b00;
        end else if (w_is_half) begin
            w_eff_addr[0] = 1'b0;
        end
    end

    // RMW merge: only the addressed lane takes new data.
    always_comb begin
        w_merged = i_mem_out_data;
        if (r_is_half) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // Lane extraction with sign or zero extension.
    always_comb begin
        w_half = i_mem_out_data[{r_addr[1], 4'b0000} +: 16];
        w_byte = i_mem_out_data[{r_addr[1:0], 3'b000} +: 8];
        if (r_is_word) begin
            w_load_data = i_mem_out_data;
        end else if (r_is_half) begin
            w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
        end else begin
            w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_next    = r_state;
        o_req_ready     = 1'b0;
        o_resp_valid    = 1'b0;
        o_mem_in_valid  = 1'b0;
        o_mem_out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_req_ready = 1'b1;
                if (w_accept) begin
                    if (w_trap) begin
                        w_state_next = StResp;
                    end else if (i_req_write && w_is_word) begin
                        w_state_next = StWr;
                    end else begin
                        w_state_next = StRd;
                    end
                end
            end
            StRd: begin
                o_mem_out_valid = 1'b1;
                if (i_mem_out_ready) begin
                    w_state_next = r_write ? StWr : StResp;
                end
            end
            StWr: begin
                o_mem_in_valid = 1'b1;
                if (i_mem_in_ready) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                o_resp_valid = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Request capture, merged write word and response registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_write      <= 1'b0;
            r_is_word    <= 1'b0;
            r_is_half    <= 1'b0;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 16'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_error <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_write    <= i_req_write;
                        r_is_word  <= w_is_word;
                        r_is_half  <= w_is_half;
                        r_unsigned <= i_req_unsigned;
                        r_addr     <= w_eff_addr;
                        r_wdata    <= i_req_wdata[15:0];
                        if (i_req_write && w_is_word) begin
                            r_mem_wdata <= i_req_wdata;
                        end
                        if (w_trap) begin
                            r_resp_rdata <= 32'd0;
                            r_resp_error <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    if (i_mem_out_ready) begin
                        if (r_write) begin
                            r_mem_wdata <= w_merged;
                        end else begin
                            r_resp_rdata <= w_load_data;
                            r_resp_error <= 1'b0;
                        end
                    end
                end
                StWr: begin
                    if (i_mem_in_ready) begin
                        r_resp_rdata <= 32'd0;
                        r_resp_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_resp_rdata   = r_resp_rdata;
    assign o_resp_error   = r_resp_error;
    assign o_mem_in_addr  = {r_addr[31:2], 2'b00};
    assign o_mem_out_addr = {r_addr[31:2], 2'b00};
    assign o_mem_in_data  = r_mem_wdata;

endmodule
